// File: rtl/fc_accumulator.sv
// FC-layer output-neuron accumulator: sums signed partial sums plus an optional bias.
// The sum is requantized with a rounding arithmetic shift and signed saturation.
module fc_accumulator #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned PSUM_WIDTH  = 20,
    parameter int unsigned ACC_WIDTH   = 32,
    parameter int unsigned SHIFT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bias_valid_i,
    input  logic [ACC_WIDTH-1:0]   bias_i,
    input  logic [SHIFT_WIDTH-1:0] shift_i,
    input  logic                   psum_valid_i,
    input  logic                   psum_last_i,
    input  logic                   layer_last_i,
    input  logic [PSUM_WIDTH-1:0]  psum_i,
    input  logic                   sat_clr_i,
    output logic                   acc_valid_o,
    output logic                   acc_last_o,
    output logic [DATA_WIDTH-1:0]  acc_result_o,
    output logic                   sat_o,
    output logic [15:0]            neuron_cnt_o
);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    localparam logic signed [ACC_WIDTH:0] RND_ONE = (ACC_WIDTH+1)'(1);
    localparam logic signed [ACC_WIDTH:0] RES_MAX = (ACC_WIDTH+1)'((2 ** (DATA_WIDTH-1)) - 1);
    localparam logic signed [ACC_WIDTH:0] RES_MIN = ~RES_MAX;

    state_t state, state_next;

    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] bias_reg;
    logic [SHIFT_WIDTH-1:0]      shift_reg;

    logic signed [ACC_WIDTH-1:0] psum_ext;
    logic signed [ACC_WIDTH-1:0] eff_bias;
    logic signed [ACC_WIDTH-1:0] acc_base;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic [SHIFT_WIDTH-1:0]      shift_eff;
    logic                        first_beat;
    logic                        emit;

    logic signed [ACC_WIDTH:0]   sum_wide;
    logic signed [ACC_WIDTH:0]   rnd;
    logic signed [ACC_WIDTH:0]   rounded;
    logic signed [ACC_WIDTH:0]   shifted;
    logic [DATA_WIDTH-1:0]       result;
    logic                        clamped;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (psum_valid_i && !psum_last_i) state_next = ACC;
            ACC:  if (psum_valid_i && psum_last_i)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A first psum takes its bias and shift straight from the inputs so a
    // neuron can open in the cycle right after the previous one emitted.
    always_comb begin
        first_beat = psum_valid_i && (state == IDLE);
        emit       = psum_valid_i && psum_last_i;
        psum_ext   = {{(ACC_WIDTH-PSUM_WIDTH){psum_i[PSUM_WIDTH-1]}}, psum_i};
        eff_bias   = bias_valid_i ? bias_i : bias_reg;
        acc_base   = (state == IDLE) ? eff_bias : acc_q;
        acc_next   = acc_base + psum_ext;
        shift_eff  = (state == IDLE) ? shift_i : shift_reg;
    end

    always_comb begin
        sum_wide = {acc_next[ACC_WIDTH-1], acc_next};
        rnd      = (shift_eff != '0) ? (RND_ONE << (shift_eff - SHIFT_WIDTH'(1))) : '0;
        rounded  = sum_wide + rnd;
        shifted  = rounded >>> shift_eff;
        clamped  = 1'b0;
        result   = shifted[DATA_WIDTH-1:0];
        if (shifted > RES_MAX) begin
            result  = RES_MAX[DATA_WIDTH-1:0];
            clamped = 1'b1;
        end else if (shifted < RES_MIN) begin
            result  = RES_MIN[DATA_WIDTH-1:0];
            clamped = 1'b1;
        end
    end

    // A bias arriving with a first psum is consumed by that neuron, so the
    // register is cleared rather than loaded in that cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q     <= '0;
            bias_reg  <= '0;
            shift_reg <= '0;
        end else begin
            if (psum_valid_i) begin
                acc_q <= acc_next;
            end
            if (first_beat) begin
                shift_reg <= shift_i;
                bias_reg  <= '0;
            end else if (bias_valid_i) begin
                bias_reg <= bias_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_valid_o  <= 1'b0;
            acc_last_o   <= 1'b0;
            acc_result_o <= '0;
            sat_o        <= 1'b0;
            neuron_cnt_o <= '0;
        end else begin
            acc_valid_o <= emit;
            acc_last_o  <= emit && layer_last_i;
            if (emit) begin
                acc_result_o <= result;
                neuron_cnt_o <= layer_last_i ? 16'd0 : neuron_cnt_o + 16'd1;
            end
            if (emit && clamped) begin
                sat_o <= 1'b1;
            end else if (sat_clr_i) begin
                sat_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fc_accumulator.sv
// Randomized scoreboard bench for fc_accumulator against a neuron-level arithmetic model.
module tb_fc_accumulator;

    localparam int DW = 8;
    localparam int PW = 20;
    localparam int AW = 32;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          bias_valid_i;
    logic [AW-1:0] bias_i;
    logic [SW-1:0] shift_i;
    logic          psum_valid_i;
    logic          psum_last_i;
    logic          layer_last_i;
    logic [PW-1:0] psum_i;
    logic          sat_clr_i;
    logic          acc_valid_o;
    logic          acc_last_o;
    logic [DW-1:0] acc_result_o;
    logic          sat_o;
    logic [15:0]   neuron_cnt_o;

    always #5 clk = ~clk;

    fc_accumulator #(
        .DATA_WIDTH (DW),
        .PSUM_WIDTH (PW),
        .ACC_WIDTH  (AW),
        .SHIFT_WIDTH(SW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bias_valid_i(bias_valid_i),
        .bias_i      (bias_i),
        .shift_i     (shift_i),
        .psum_valid_i(psum_valid_i),
        .psum_last_i (psum_last_i),
        .layer_last_i(layer_last_i),
        .psum_i      (psum_i),
        .sat_clr_i   (sat_clr_i),
        .acc_valid_o (acc_valid_o),
        .acc_last_o  (acc_last_o),
        .acc_result_o(acc_result_o),
        .sat_o       (sat_o),
        .neuron_cnt_o(neuron_cnt_o)
    );

    typedef struct {
        longint res;
        bit     last;
        int     cnt;
        bit     sat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Neuron-level model: running sum of the open neuron, pending bias, counters.
    bit     m_open = 0;
    longint m_sum  = 0;
    int     m_k    = 0;
    longint m_bias = 0;
    int     m_cnt  = 0;
    bit     m_sat  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint requant(input longint s, input int k, output bit clamped);
        longint rnd;
        longint r;
        rnd = (k > 0) ? (longint'(1) <<< (k - 1)) : 0;
        r   = (s + rnd) >>> k;
        clamped = 1'b0;
        if (r > 127) begin
            r = 127;
            clamped = 1'b1;
        end else if (r < -128) begin
            r = -128;
            clamped = 1'b1;
        end
        return r;
    endfunction

    task automatic beat(input bit v, input bit l, input bit ll, input int p, input int k,
                        input bit bv, input int b, input bit clr);
        bit     cl;
        longint res;
        exp_t   e;
        psum_valid_i = v;
        psum_last_i  = l;
        layer_last_i = ll;
        psum_i       = p[PW-1:0];
        shift_i      = k[SW-1:0];
        bias_valid_i = bv;
        bias_i       = b;
        sat_clr_i    = clr;
        if (v) begin
            if (!m_open) begin
                m_sum  = (bv ? longint'(b) : m_bias) + p;
                m_k    = k;
                m_bias = 0;
                m_open = 1;
            end else begin
                m_sum = m_sum + p;
                if (bv) m_bias = b;
            end
            m_sum = longint'(int'(m_sum));
        end else if (bv) begin
            m_bias = b;
        end
        if (v && l) begin
            res    = requant(m_sum, m_k, cl);
            m_open = 0;
            if (cl) m_sat = 1;
            else if (clr) m_sat = 0;
            m_cnt  = ll ? 0 : m_cnt + 1;
            e.res  = res;
            e.last = ll;
            e.cnt  = m_cnt;
            e.sat  = m_sat;
            sb.push_back(e);
        end else if (clr) begin
            m_sat = 0;
        end
        @(negedge clk);
        if (clr) check("sat_after_clr", sat_o, m_sat);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_valid", acc_valid_o, 0);
        check("rst_last", acc_last_o, 0);
        check("rst_result", acc_result_o, 0);
        check("rst_sat", sat_o, 0);
        check("rst_cnt", neuron_cnt_o, 0);
    endtask

    task automatic mid_reset();
        #2 rst = 1'b0;
        #1 check_reset_outputs();
        m_open = 0;
        m_sum  = 0;
        m_k    = 0;
        m_bias = 0;
        m_cnt  = 0;
        m_sat  = 0;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
    endtask

    // Monitor: every valid pulse must match the oldest expected result.
    initial begin
        longint last_res = 0;
        exp_t   e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                last_res = 0;
                continue;
            end
            if (acc_valid_o) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got result %0d expected no output at %0t",
                             $signed(acc_result_o), $time);
                end else begin
                    e = sb.pop_front();
                    check("result", $signed(acc_result_o), e.res);
                    check("last", acc_last_o, e.last);
                    check("neuron_cnt", neuron_cnt_o, e.cnt);
                    check("sat", sat_o, e.sat);
                end
                last_res = $signed(acc_result_o);
            end else begin
                check("last_without_valid", acc_last_o, 0);
                check("result_hold", $signed(acc_result_o), last_res);
            end
        end
    end

    initial begin
        int  p;
        int  b;
        bit  v;
        rst          = 1'b0;
        bias_valid_i = 1'b0;
        bias_i       = '0;
        shift_i      = '0;
        psum_valid_i = 1'b0;
        psum_last_i  = 1'b0;
        layer_last_i = 1'b0;
        psum_i       = '0;
        sat_clr_i    = 1'b0;
        #3 check_reset_outputs();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);

        // basic sum
        beat(1, 0, 0, 10, 0, 0, 0, 0);
        beat(1, 0, 0, 20, 0, 0, 0, 0);
        beat(1, 1, 0, 30, 0, 0, 0, 0);
        idle(1);
        // bias, rounding, bias consumption
        beat(0, 0, 0, 0, 0, 1, 5, 0);
        beat(1, 0, 0, 100, 2, 0, 0, 0);
        beat(1, 1, 0, -3, 0, 0, 0, 0);
        beat(1, 1, 0, 7, 0, 0, 0, 0);
        idle(1);
        // saturation both ways, then clear
        beat(1, 0, 0, 200, 0, 0, 0, 0);
        beat(1, 1, 0, 100, 0, 0, 0, 0);
        beat(1, 1, 0, -500, 0, 0, 0, 0);
        idle(1);
        beat(0, 0, 0, 0, 0, 0, 0, 1);
        // back-to-back single-term neurons ending the layer
        beat(1, 1, 0, 1, 0, 0, 0, 0);
        beat(1, 1, 0, 2, 0, 0, 0, 0);
        beat(1, 1, 1, 3, 0, 0, 0, 0);
        // gaps and same-cycle bias
        beat(1, 0, 0, 4, 0, 0, 0, 0);
        idle(3);
        beat(1, 1, 0, 6, 0, 0, 0, 0);
        beat(1, 0, 0, 1, 0, 1, 9, 0);
        beat(1, 1, 0, 1, 0, 0, 0, 0);
        beat(1, 1, 0, 2, 0, 0, 0, 0);
        // accumulator wrap and extreme shifts
        beat(1, 1, 0, 1, 0, 1, 32'h7fffffff, 0);
        beat(1, 1, 0, -1, 31, 1, 32'h80000000, 0);
        beat(1, 1, 0, 0, 31, 1, 32'h40000000, 0);
        beat(1, 1, 0, 3, 1, 0, 0, 0);
        beat(1, 1, 0, -3, 1, 0, 0, 0);
        idle(1);
        // reset mid-neuron
        beat(1, 0, 0, 50, 0, 0, 0, 0);
        beat(1, 0, 0, 50, 0, 1, 77, 0);
        idle(1);
        mid_reset();
        beat(1, 1, 0, 3, 0, 0, 0, 0);
        idle(1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            v = $urandom_range(0, 9) < 7;
            if ($urandom_range(0, 1) == 0) p = int'($urandom_range(0, 600)) - 300;
            else p = int'($urandom_range(0, (1 << PW) - 1)) - (1 << (PW - 1));
            b = int'($urandom) >>> $urandom_range(8, 31);
            beat(v, $urandom_range(0, 9) < 3, $urandom_range(0, 4) == 0, p,
                 int'($urandom_range(0, 31)), $urandom_range(0, 7) == 0, b,
                 $urandom_range(0, 19) == 0);
        end
        idle(4);
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
